// File: rtl/store_size_unit.sv
// Store path for SW/SH/SB into a word-wide data memory.
// Sub-word stores read the old word, merge the new lanes, then write the word back.
module store_size_unit #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    ERR
  } stateT;

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [2:0] CNT_LOAD = 3'(MEM_RD_LAT - 1);

  stateT       stateReg, stateNext;
  logic [1:0]  opReg, opNext;
  logic [31:0] addrReg, addrNext;
  // Only the low halfword is ever merged; SW takes its data straight from the input.
  logic [15:0] wdataReg, wdataNext;
  logic [2:0]  cntReg, cntNext;
  logic [31:0] memWdataReg, memWdataNext;
  logic        memWrReg, memWrNext;
  logic        busyReg, busyNext;
  logic        doneReg, doneNext;
  logic        errReg, errNext;

  logic        badReq;
  logic [31:0] mergedWord;

  // Reserved op, or the access does not fit its natural alignment.
  assign badReq = (op == OP_RSV) ||
                  ((op == OP_SW) && (addr[1:0] != 2'b00)) ||
                  ((op == OP_SH) && addr[0]);

  // Little-endian lane merge: each byte lane picks new data or the old memory byte.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
      localparam logic [1:0] LANE = 2'(gi);
      logic       laneHit;
      logic [7:0] laneData;

      assign laneHit  = (opReg == OP_SB) ? (addrReg[1:0] == LANE)
                                         : (addrReg[1] == LANE[1]);
      assign laneData = (opReg == OP_SB) ? wdataReg[7:0]
                                         : wdataReg[(gi % 2) * 8 +: 8];
      assign mergedWord[gi * 8 +: 8] = laneHit ? laneData : mem_rdata[gi * 8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg    <= IDLE;
      opReg       <= 2'b00;
      addrReg     <= 32'h0;
      wdataReg    <= 16'h0;
      cntReg      <= 3'd0;
      memWdataReg <= 32'h0;
      memWrReg    <= 1'b0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      errReg      <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      opReg       <= opNext;
      addrReg     <= addrNext;
      wdataReg    <= wdataNext;
      cntReg      <= cntNext;
      memWdataReg <= memWdataNext;
      memWrReg    <= memWrNext;
      busyReg     <= busyNext;
      doneReg     <= doneNext;
      errReg      <= errNext;
    end
  end

  always_comb begin
    stateNext    = stateReg;
    opNext       = opReg;
    addrNext     = addrReg;
    wdataNext    = wdataReg;
    cntNext      = cntReg;
    memWdataNext = memWdataReg;
    memWrNext    = 1'b0;
    busyNext     = 1'b0;
    doneNext     = 1'b0;
    errNext      = 1'b0;

    unique case (stateReg)
      IDLE: begin
        if (start) begin
          opNext    = op;
          addrNext  = addr;
          wdataNext = wdata[15:0];
          if (badReq) begin
            stateNext = ERR;
          end else if (op == OP_SW) begin
            stateNext    = WRITE;
            memWdataNext = wdata;
          end else begin
            stateNext = READ;
            cntNext   = CNT_LOAD;
          end
        end
      end
      READ: begin
        // mem_rdata is valid on the final READ edge only.
        if (cntReg == 3'd0) begin
          memWdataNext = mergedWord;
          stateNext    = WRITE;
        end else begin
          cntNext = cntReg - 3'd1;
        end
      end
      WRITE:   stateNext = DONE;
      DONE:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    memWrNext = (stateNext == WRITE);
    busyNext  = (stateNext != IDLE);
    doneNext  = (stateNext == DONE) || (stateNext == ERR);
    errNext   = (stateNext == ERR);
  end

  assign mem_addr  = {addrReg[31:2], 2'b00};
  assign mem_wr    = memWrReg;
  assign mem_wdata = memWdataReg;
  assign busy      = busyReg;
  assign done      = doneReg;
  assign err       = errReg;

endmodule

// File: tb/tb_store_size_unit.sv
// Directed bench for store_size_unit: one instance with 1-cycle and one with
// 3-cycle read latency, each scenario checked in its own task.
module tb_store_size_unit;

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        startA, startB;
  logic [1:0]  op;
  logic [31:0] addr, wdata, memRdata;

  logic [31:0] memAddrA, memWdataA, memAddrB, memWdataB;
  logic        memWrA, busyA, doneA, errA;
  logic        memWrB, busyB, doneB, errB;

  int passCount = 0;
  int totalCount = 0;

  logic        logWr[0:15];
  logic [31:0] logAddr[0:15];
  logic [31:0] logWdata[0:15];
  logic        logDone[0:15];
  logic        logErr[0:15];
  logic        logBusy[0:15];

  always #5 clk = ~clk;

  store_size_unit #(.MEM_RD_LAT(1)) dutA (
    .clk(clk), .reset(reset), .start(startA), .op(op), .addr(addr), .wdata(wdata),
    .mem_rdata(memRdata), .mem_addr(memAddrA), .mem_wr(memWrA), .mem_wdata(memWdataA),
    .busy(busyA), .done(doneA), .err(errA)
  );

  store_size_unit #(.MEM_RD_LAT(3)) dutB (
    .clk(clk), .reset(reset), .start(startB), .op(op), .addr(addr), .wdata(wdata),
    .mem_rdata(memRdata), .mem_addr(memAddrB), .mem_wr(memWrB), .mem_wdata(memWdataB),
    .busy(busyB), .done(doneB), .err(errB)
  );

  // Pulse start on one instance, then log its outputs n cycles after the sampling
  // edge (index i = cycle k+i). injectAt>0 raises an extra SW start at that index.
  task automatic runStore(input logic sel, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] d, input int n, input int injectAt);
    @(negedge clk);
    op = o; addr = a; wdata = d;
    if (sel) startB = 1'b1; else startA = 1'b1;
    $display("txn dut=%s op=%b addr=%h wdata=%h rdata=%h", sel ? "B" : "A", o, a, d, memRdata);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      logWr[i]    = sel ? memWrB : memWrA;
      logAddr[i]  = sel ? memAddrB : memAddrA;
      logWdata[i] = sel ? memWdataB : memWdataA;
      logDone[i]  = sel ? doneB : doneA;
      logErr[i]   = sel ? errB : errA;
      logBusy[i]  = sel ? busyB : busyA;
      startA = 1'b0; startB = 1'b0;
      if (i == injectAt && i < n) begin
        op = OP_SW; addr = 32'h0000_0100; wdata = 32'h5555_5555;
        if (sel) startB = 1'b1; else startA = 1'b1;
      end
    end
    startA = 1'b0; startB = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; startA = 1'b0; startB = 1'b0;
    op = OP_SW; addr = 32'h0; wdata = 32'h0; memRdata = 32'h0;
    repeat (3) @(negedge clk);
    totalCount++; if ({memWrA, busyA, doneA, errA} !== 4'b0000) $display("FAIL reset_ctl: got %b want 0000", {memWrA, busyA, doneA, errA}); else passCount++;
    totalCount++; if (memAddrA !== 32'h0) $display("FAIL reset_addr: got %h want 00000000", memAddrA); else passCount++;
    totalCount++; if (memWdataA !== 32'h0) $display("FAIL reset_wdata: got %h want 00000000", memWdataA); else passCount++;
    reset = 1'b0;
    @(negedge clk);
    totalCount++; if ({memWrB, busyB, doneB, errB} !== 4'b0000) $display("FAIL reset_idle_b: got %b want 0000", {memWrB, busyB, doneB, errB}); else passCount++;
  endtask

  task automatic test_sw();
    runStore(1'b0, OP_SW, 32'h0000_0010, 32'hDEAD_BEEF, 2, 0);
    totalCount++; if (logWr[1] !== 1'b1) $display("FAIL sw_wr_k1: got %b want 1", logWr[1]); else passCount++;
    totalCount++; if (logAddr[1] !== 32'h0000_0010) $display("FAIL sw_addr: got %h want 00000010", logAddr[1]); else passCount++;
    totalCount++; if (logWdata[1] !== 32'hDEAD_BEEF) $display("FAIL sw_wdata: got %h want deadbeef", logWdata[1]); else passCount++;
    totalCount++; if (logDone[1] !== 1'b0) $display("FAIL sw_done_early: got %b want 0", logDone[1]); else passCount++;
    totalCount++; if ({logWr[2], logDone[2], logErr[2], logBusy[2]} !== 4'b0101) $display("FAIL sw_done_k2: got %b want 0101", {logWr[2], logDone[2], logErr[2], logBusy[2]}); else passCount++;
  endtask

  task automatic test_sb_lat1();
    memRdata = 32'h1122_3344;
    runStore(1'b0, OP_SB, 32'h0000_0023, 32'h0000_00AB, 3, 0);
    totalCount++; if ({logWr[1], logBusy[1]} !== 2'b01) $display("FAIL sb_read_k1: got %b want 01", {logWr[1], logBusy[1]}); else passCount++;
    totalCount++; if (logWr[2] !== 1'b1) $display("FAIL sb_wr_k2: got %b want 1", logWr[2]); else passCount++;
    totalCount++; if (logAddr[2] !== 32'h0000_0020) $display("FAIL sb_addr: got %h want 00000020", logAddr[2]); else passCount++;
    totalCount++; if (logWdata[2] !== 32'hAB22_3344) $display("FAIL sb_merge: got %h want ab223344", logWdata[2]); else passCount++;
    totalCount++; if ({logWr[3], logDone[3], logErr[3]} !== 3'b010) $display("FAIL sb_done_k3: got %b want 010", {logWr[3], logDone[3], logErr[3]}); else passCount++;
  endtask

  task automatic test_sh_lat3();
    int wrCount;
    memRdata = 32'h1122_3344;
    runStore(1'b1, OP_SH, 32'h0000_0042, 32'h0000_CAFE, 5, 0);
    wrCount = 0;
    for (int i = 1; i <= 3; i++) if (logWr[i]) wrCount++;
    totalCount++; if (wrCount !== 0) $display("FAIL sh_read_nowr: got %0d writes want 0", wrCount); else passCount++;
    totalCount++; if (logWr[4] !== 1'b1) $display("FAIL sh_wr_k4: got %b want 1", logWr[4]); else passCount++;
    totalCount++; if (logAddr[4] !== 32'h0000_0040) $display("FAIL sh_addr: got %h want 00000040", logAddr[4]); else passCount++;
    totalCount++; if (logWdata[4] !== 32'hCAFE_3344) $display("FAIL sh_merge: got %h want cafe3344", logWdata[4]); else passCount++;
    totalCount++; if ({logWr[5], logDone[5]} !== 2'b01) $display("FAIL sh_done_k5: got %b want 01", {logWr[5], logDone[5]}); else passCount++;
  endtask

  task automatic test_merge_lanes();
    memRdata = 32'h1122_3344;
    runStore(1'b1, OP_SB, 32'h0000_000C, 32'hFFFF_FF77, 5, 0);
    totalCount++; if (logWdata[4] !== 32'h1122_3377) $display("FAIL sb_lane0: got %h want 11223377", logWdata[4]); else passCount++;
    runStore(1'b1, OP_SH, 32'h0000_0050, 32'hFFFF_BEEF, 5, 0);
    totalCount++; if (logWdata[4] !== 32'h1122_BEEF) $display("FAIL sh_low: got %h want 1122beef", logWdata[4]); else passCount++;
    runStore(1'b0, OP_SB, 32'h0000_0032, 32'h0000_0099, 3, 0);
    totalCount++; if (logWdata[2] !== 32'h1199_3344) $display("FAIL sb_lane2: got %h want 11993344", logWdata[2]); else passCount++;
  endtask

  task automatic test_errors();
    logic [1:0]  errOp[0:2]   = '{OP_SH, OP_SW, OP_RSV};
    logic [31:0] errAddr[0:2] = '{32'h0000_0041, 32'h0000_0002, 32'h0000_0000};
    int wrCount;
    for (int t = 0; t < 3; t++) begin
      runStore(1'b0, errOp[t], errAddr[t], 32'h1234_5678, 3, 0);
      wrCount = 0;
      for (int i = 1; i <= 3; i++) if (logWr[i]) wrCount++;
      totalCount++; if ({logDone[1], logErr[1]} !== 2'b11) $display("FAIL err%0d_k1: got %b want 11", t, {logDone[1], logErr[1]}); else passCount++;
      totalCount++; if (wrCount !== 0) $display("FAIL err%0d_nowr: got %0d writes want 0", t, wrCount); else passCount++;
      totalCount++; if ({logDone[2], logErr[2], logBusy[2]} !== 3'b000) $display("FAIL err%0d_k2: got %b want 000", t, {logDone[2], logErr[2], logBusy[2]}); else passCount++;
    end
  endtask

  task automatic test_back_to_back();
    int wrCount;
    memRdata = 32'h1122_3344;
    runStore(1'b1, OP_SB, 32'h0000_0031, 32'h0000_005A, 5, 1);
    wrCount = 0;
    for (int i = 1; i <= 5; i++) if (logWr[i]) wrCount++;
    totalCount++; if (wrCount !== 1) $display("FAIL busy_one_wr: got %0d writes want 1", wrCount); else passCount++;
    totalCount++; if (logAddr[4] !== 32'h0000_0030) $display("FAIL busy_addr: got %h want 00000030", logAddr[4]); else passCount++;
    totalCount++; if (logWdata[4] !== 32'h1122_5A44) $display("FAIL busy_merge: got %h want 11225a44", logWdata[4]); else passCount++;
    totalCount++; if (logDone[5] !== 1'b1) $display("FAIL busy_done: got %b want 1", logDone[5]); else passCount++;
    runStore(1'b1, OP_SW, 32'h0000_0200, 32'h1234_5678, 2, 0);
    totalCount++; if ({logWr[1], logAddr[1]} !== {1'b1, 32'h0000_0200}) $display("FAIL b2b_wr: got %b/%h want 1/00000200", logWr[1], logAddr[1]); else passCount++;
    totalCount++; if (logDone[2] !== 1'b1) $display("FAIL b2b_done: got %b want 1", logDone[2]); else passCount++;
  endtask

  task automatic test_reset_mid();
    int wrCount;
    int doneCount;
    memRdata = 32'h1122_3344;
    @(negedge clk);
    op = OP_SB; addr = 32'h0000_0023; wdata = 32'h0000_00AB; startB = 1'b1;
    $display("txn dut=B op=%b addr=%h wdata=%h (reset during READ)", op, addr, wdata);
    @(negedge clk);
    startB = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    totalCount++; if ({memWrB, busyB, doneB, errB} !== 4'b0000) $display("FAIL rst_mid_ctl: got %b want 0000", {memWrB, busyB, doneB, errB}); else passCount++;
    totalCount++; if (memAddrB !== 32'h0) $display("FAIL rst_mid_addr: got %h want 00000000", memAddrB); else passCount++;
    totalCount++; if (memWdataB !== 32'h0) $display("FAIL rst_mid_wdata: got %h want 00000000", memWdataB); else passCount++;
    @(negedge clk);
    reset = 1'b0;
    wrCount = 0; doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (memWrB) wrCount++;
      if (doneB) doneCount++;
    end
    totalCount++; if (wrCount !== 0 || doneCount !== 0) $display("FAIL rst_mid_quiet: got %0d writes %0d done want 0 0", wrCount, doneCount); else passCount++;
    runStore(1'b1, OP_SW, 32'h0000_0044, 32'hA5A5_A5A5, 2, 0);
    totalCount++; if ({logWr[1], logWdata[1]} !== {1'b1, 32'hA5A5_A5A5}) $display("FAIL rst_mid_sw: got %b/%h want 1/a5a5a5a5", logWr[1], logWdata[1]); else passCount++;
    totalCount++; if (logDone[2] !== 1'b1) $display("FAIL rst_mid_sw_done: got %b want 1", logDone[2]); else passCount++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb_lat1();
    test_sh_lat3();
    test_merge_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/store_size_unit.md
Name: store_size_unit

Overview:
- Write-side counterpart of the load-size/writeback path. Executes SW, SH and SB stores into the word-wide data memory.
- SW is a direct word write. SH and SB use a read-modify-write sequence: read the old word, merge the new byte or halfword, write the word back.
- Sits between the control FSM and the data memory, driven by the ALUOut address and the B register.

Parameters:
- MEM_RD_LAT, 1, memory read latency in cycles from address presented to mem_rdata valid (legal range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle store request; sampled only in IDLE.
- op  input  2  store size: 00 SW, 01 SH, 10 SB, 11 reserved.
- addr  input  32  byte address (from ALUOut).
- wdata  input  32  store data (from B); SH uses bits 15:0, SB uses bits 7:0.
- mem_rdata  input  32  memory read data.
- mem_addr  output  32  word address {addr_q[31:2],2'b00}.
- mem_wr  output  1  memory write enable; high for exactly one cycle per successful store.
- mem_wdata  output  32  word to write.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse, coincident with done, for a misaligned or reserved request.

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset (asynchronous, any state): state IDLE, busy=0, done=0, err=0, mem_wr=0, mem_addr=0, mem_wdata=0, latency counter=0, latched registers=0.
  - A reset asserted mid-operation aborts the store.
  - mem_wr drops immediately; no partial write is completed after reset release.
- Byte lanes are little-endian: offset 0 = bits 7:0, offset 3 = bits 31:24.
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE:
  - On start=1, latch op, addr, wdata into op_q, addr_q, wdata_q.
  - start while not IDLE is ignored; no queuing.
  - Error check on the latched request, in priority order:
    - op=11 -> ERR.
    - SW with addr[1:0]!=0 -> ERR.
    - SH with addr[0]=1 -> ERR.
  - Otherwise SW -> WRITE; SH or SB -> READ.
- READ:
  - mem_addr driven, mem_wr=0. Stays MEM_RD_LAT cycles (counter loaded with MEM_RD_LAT-1, decrements).
  - On the last READ edge, the merged word is registered into mem_wdata, then -> WRITE.
  - SB: replace lane addr_q[1:0] with wdata_q[7:0]; other lanes from mem_rdata.
  - SH: addr_q[1]=0 replaces bits 15:0; addr_q[1]=1 replaces bits 31:16. Replacement data is wdata_q[15:0].
- WRITE:
  - mem_wr=1 for one cycle; mem_addr stable.
  - mem_wdata is wdata_q for SW, the merged word for SH/SB.
  - -> DONE.
- DONE: done=1 for one cycle, mem_wr=0, -> IDLE.
- ERR: done=1 and err=1 for one cycle, no memory access at all, -> IDLE.
- Latency, with start sampled at edge k:
  - SW: mem_wr in cycle k+1, done in cycle k+2.
  - SH/SB: READ in cycles k+1..k+MEM_RD_LAT, mem_wr at k+MEM_RD_LAT+1, done at k+MEM_RD_LAT+2.
  - Error: done/err at k+1.
- mem_addr, mem_wdata hold their last values in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- A new start is accepted in the cycle after done (back-to-back stores allowed).

Test Plan:
- Reset, then SW: addr=0x0000_0010, wdata=0xDEADBEEF -> mem_wr high one cycle at k+1 with mem_addr=0x10, mem_wdata=0xDEADBEEF; done at k+2; err=0.
- SB, MEM_RD_LAT=1: addr=0x0000_0023, wdata=0x000000AB, mem_rdata=0x11223344 -> mem_wr at k+2 with mem_addr=0x20, mem_wdata=0xAB223344; done at k+3.
- SH, MEM_RD_LAT=3: addr=0x0000_0042, wdata=0x0000CAFE, mem_rdata=0x11223344 -> 3 READ cycles; mem_wdata=0xCAFE3344; mem_wr at k+4.
- Errors:
  - SH at addr=0x0000_0041 -> done=err=1 at k+1, mem_wr never asserted.
  - SW at addr=0x0000_0002 -> same response.
  - op=11 -> same response.
- Busy handling: second start during READ ignored (only one mem_wr observed). Then start the cycle after done -> accepted.
- Reset asserted during READ of an SB -> all outputs 0 asynchronously, no mem_wr after release; a subsequent SW completes normally.
